// File: rtl/svi_collect_pkg.sv
// Shared types and helpers for the SVI lane collector.
// SVI_COLLECT_LANE_TAG_EN selects tagged {lane,data} FIFO entries.
package svi_collect_pkg;

  localparam int NLANES_DEF = 3;
  localparam int W_DEF      = 8;
  localparam int DEPTH_DEF  = 4;

  function automatic int lane_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int LANE_W_DEF = lane_w(NLANES_DEF);

  typedef logic [LANE_W_DEF-1:0] lane_idx_t;

  typedef struct packed {
    lane_idx_t        lane;
    logic [W_DEF-1:0] data;
  } tag_entry_t;

endpackage

// File: rtl/svi_collect_fifo.sv
// Synchronous FIFO with registered storage and a held last-popped value.
// Head output never depends combinationally on the write port.
module svi_collect_fifo #(
  parameter int EW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [EW-1:0]          din_i,
  output logic [EW-1:0]          dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   lvl_q, lvl_d;
  logic [EW-1:0] last_q;
  logic          push_ok, pop_ok;

  assign full_o  = (lvl_q == FULL_LVL);
  assign empty_o = (lvl_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign level_o = lvl_q;
  assign dout_o  = empty_o ? last_q : mem_q[rd_q];

  // Occupancy follows push/pop; both together leave it unchanged.
  always_comb begin
    lvl_d = lvl_q;
    unique case ({push_ok, pop_ok})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
  end

  // Storage, pointers and the held output value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      last_q <= '0;
    end else begin
      lvl_q <= lvl_d;
      if (push_ok) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_ok) begin
        last_q <= mem_q[rd_q];
        rd_q   <= rd_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/svi_lane_collector.sv
// Round-robin merge of valid/ready lanes into one FIFO-backed stream.
// SVI_COLLECT_LANE_TAG_EN adds the out_lane port and tagged entries.
module svi_lane_collector
  import svi_collect_pkg::*;
#(
  parameter int NLANES = 3,
  parameter int W      = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NLANES-1:0]      in_valid,
  input  logic [NLANES*W-1:0]    in_data,
  output logic [NLANES-1:0]      in_ready,
  output logic                   out_valid,
  output logic [W-1:0]           out_data,
  input  logic                   out_ready,
`ifdef SVI_COLLECT_LANE_TAG_EN
  output logic [lane_w(NLANES)-1:0] out_lane,
`endif
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int LANE_W = lane_w(NLANES);
`ifdef SVI_COLLECT_LANE_TAG_EN
  localparam int EW = LANE_W + W;
`else
  localparam int EW = W;
`endif

  logic [LANE_W-1:0] rr_q, rr_d, grant;
  logic              any_v, push, full, empty;
  logic [EW-1:0]     din, dout;
  int                idx;

  // First valid lane at or after rr_q, scanned modulo NLANES.
  always_comb begin
    grant = '0;
    any_v = 1'b0;
    idx   = 0;
    for (int k = NLANES-1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= NLANES) idx = idx - NLANES;
      if (in_valid[idx]) begin
        grant = LANE_W'(idx);
        any_v = 1'b1;
      end
    end
  end

  // Grant only when space exists; a pop in the same cycle does not help.
  assign push     = any_v && !full && rst_n;
  assign in_ready = push ? (NLANES'(1) << grant) : '0;

`ifdef SVI_COLLECT_LANE_TAG_EN
  assign din      = {grant, in_data[grant*W +: W]};
  assign out_lane = dout[W +: LANE_W];
`else
  assign din      = in_data[grant*W +: W];
`endif
  assign out_data  = dout[W-1:0];
  assign out_valid = !empty;

  // Pointer moves past the granted lane only on a push.
  always_comb begin
    rr_d = rr_q;
    if (push)
      rr_d = (int'(grant) == NLANES-1) ? '0 : grant + 1'b1;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= '0;
    else        rr_q <= rr_d;
  end

  svi_collect_fifo #(
    .EW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (out_ready),
    .din_i   (din),
    .dout_o  (dout),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

endmodule

// File: tb/tb_svi_lane_collector.sv
// Scoreboard bench for svi_lane_collector (NLANES=3, W=8, DEPTH=4).
// Define SVI_COLLECT_LANE_TAG_EN to also check out_lane.
module tb_svi_lane_collector;
  import svi_collect_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  in_valid;
  logic [23:0] in_data;
  logic [2:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [2:0]  fifo_level;
`ifdef SVI_COLLECT_LANE_TAG_EN
  logic [1:0]  out_lane;
`endif

  svi_lane_collector #(.NLANES(3), .W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
`ifdef SVI_COLLECT_LANE_TAG_EN
    .out_lane   (out_lane),
`endif
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int         ncmp = 0;
  int         nerr = 0;
  int         mlevel, mrr;
  tag_entry_t sb[$];
  logic [7:0] got[$];
  logic [2:0] last_ready;
  bit         last_push;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    mlevel = 0;
    mrr    = 0;
  endtask

  task automatic step();
    logic [2:0] er;
    int         g;
    int         id;
    bit         pu, po;
    tag_entry_t e;
    @(negedge clk);
    er = '0;
    g  = -1;
    if (rst_n && mlevel < 4)
      for (int k = 0; k < 3; k++) begin
        id = (mrr + k) % 3;
        if (in_valid[id] && g < 0) g = id;
      end
    if (g >= 0) er[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("fifo_level", 32'(fifo_level), 32'(mlevel));
    chk("out_valid", 32'(out_valid), 32'(mlevel != 0));
    po = (mlevel != 0) && out_ready;
    if (mlevel != 0) begin
      e = sb[0];
      chk("out_data", 32'(out_data), 32'(e.data));
`ifdef SVI_COLLECT_LANE_TAG_EN
      chk("out_lane", 32'(out_lane), 32'(e.lane));
`endif
    end
    if (po) begin
      void'(sb.pop_front());
      got.push_back(out_data);
    end
    pu = (g >= 0);
    if (pu) begin
      e.lane = 2'(g);
      e.data = in_data[g*8 +: 8];
      sb.push_back(e);
    end
    last_ready = in_ready;
    last_push  = pu;
    @(posedge clk);
    mlevel = mlevel + int'(pu) - int'(po);
    if (pu) mrr = (g + 1) % 3;
    #1;
  endtask

  initial begin
    logic [7:0] vals [5];
    logic [7:0] rrx  [6];
    logic [2:0] gx   [4];
    int         k;
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rrx  = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'hFF, 8'hA5};
    gx   = '{3'b100, 3'b001, 3'b100, 3'b001};

    // reset with random inputs
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid  = 3'($urandom);
      in_data   = 24'($urandom);
      out_ready = 1'($urandom);
      step();
      chk("rst_out_data", 32'(out_data), 32'h0);
    end

    // round robin, released with lanes already valid
    rst_n     = 1'b1;
    in_valid  = 3'b111;
    in_data   = {8'hA5, 8'hFF, 8'h00};
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 9; i++) step();
    for (int i = 0; i < 6; i++) chk("rr_seq", 32'(got[i]), 32'(rrx[i]));
    in_valid = 3'b000;
    for (int i = 0; i < 3; i++) step();

    // fill to full from lane 1
    out_ready = 1'b0;
    in_valid  = 3'b010;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      in_data[15:8] = vals[k];
      step();
      if (last_push) k++;
    end
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("full_ready1", 32'(last_ready[1]), 32'd0);
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      if (k < 5) begin
        in_valid      = 3'b010;
        in_data[15:8] = vals[k];
      end else begin
        in_valid = 3'b000;
      end
      step();
      if (last_push) k++;
    end
    chk("full_cnt", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk("full_seq", 32'(got[i]), 32'(vals[i]));

    // wrap and skip lane 1, pointer starts at 2
    in_valid = 3'b101;
    in_data  = {8'h2C, 8'h77, 8'h0A};
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wrap_grant", 32'(last_ready), 32'(gx[i]));
    end
    in_valid = 3'b000;
    for (int i = 0; i < 2; i++) step();

    // mid-stream reset discards queued entries
    out_ready = 1'b0;
    in_valid  = 3'b001;
    for (int i = 0; i < 3; i++) begin
      in_data[7:0] = 8'h70 + 8'(i);
      step();
    end
    chk("pre_flush_level", 32'(fifo_level), 32'd3);
    in_valid = 3'b000;
    rst_n    = 1'b0;
    model_reset();
    step();
    chk("flush_level", 32'(fifo_level), 32'd0);
    rst_n = 1'b1;
    step();
    chk("flush_valid", 32'(out_valid), 32'd0);
    in_valid     = 3'b001;
    in_data[7:0] = 8'h90;
    step();
    in_valid  = 3'b000;
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 3; i++) step();
    chk("flush_cnt", 32'(got.size()), 32'd1);
    chk("flush_data", 32'(got[0]), 32'h90);

    // steady push and pop at level 2
    out_ready = 1'b0;
    in_valid  = 3'b001;
    in_data[7:0] = 8'hC0;
    step();
    in_data[7:0] = 8'hC1;
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data[7:0] = 8'hC2 + 8'(i);
      step();
      chk("lvl2", 32'(fifo_level), 32'd2);
    end
    in_valid = 3'b000;
    for (int i = 0; i < 4; i++) step();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
